// File: rtl/stdp_pkg.sv
// Shared types and default sizing for the STDP sweep pipeline.
// The collector states and the default slot/weight widths live here.
package stdp_pkg;

    localparam int N_SLOTS_DEFAULT = 16;
    localparam int SLOT_IDX_W      = 4;
    localparam int WEIGHT_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } collector_state_t;

endpackage

// File: rtl/stdp_weight_collector_if.sv
// Write-in and drain-out ports of the weight collector.
// The collector is the slave; the stage-2 producer and the memory writer form the master side.
interface stdp_weight_collector_if
    import stdp_pkg::*;
#(
    parameter int IDX_W  = SLOT_IDX_W,
    parameter int DATA_W = WEIGHT_W
);

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_en, wr_idx, wr_data, rd_ready,
        input  rd_valid, rd_idx, rd_data
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, rd_ready,
        output rd_valid, rd_idx, rd_data
    );

endinterface

// File: rtl/stdp_weight_collector_slot_bitmap.sv
// Per-frame arrival bitmap: one bit per slot, flags repeated or out-of-range slots,
// and reports whether the bitmap will be complete once this cycle's set lands.
module slot_bitmap #(
    parameter int N_SLOTS = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    output logic             dup,
    output logic             accept,
    output logic             all_set
);

    logic [N_SLOTS-1:0] bits_q;
    logic [N_SLOTS-1:0] bits_d;
    logic [N_SLOTS-1:0] base;
    logic [N_SLOTS-1:0] mask;
    logic               in_range;
    logic               hit;

    // A clear and a set in the same cycle act on the freshly cleared bitmap.
    always_comb begin
        base     = clear ? '0 : bits_q;
        in_range = (32'(set_idx) < 32'(N_SLOTS));
        mask     = in_range ? (N_SLOTS'(1) << set_idx) : '0;
        hit      = |(base & mask);
        dup      = set_en && (!in_range || hit);
        accept   = set_en && in_range && !hit;
        bits_d   = accept ? (base | mask) : base;
        all_set  = &bits_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/stdp_weight_collector.sv
// Captures one sweep of slot-tagged weight updates, then drains them in ascending
// slot order over a valid/ready port once every slot has arrived.
module stdp_weight_collector
    import stdp_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEFAULT,
    parameter int IDX_W   = SLOT_IDX_W,
    parameter int DATA_W  = WEIGHT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sweep_start,
    stdp_weight_collector_if.slave bus,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   dup_err,
    output logic                   ovr_err
);

    collector_state_t  state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              dup_err_q, dup_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic [DATA_W-1:0] slot_buf_q [N_SLOTS];
    logic [DATA_W-1:0] slot_buf_d [N_SLOTS];

    logic              collecting;
    logic              bm_clear;
    logic              bm_set_en;
    logic              bm_dup;
    logic              bm_accept;
    logic              bm_all_set;
    logic              rd_fire;
    logic              rd_last;
    logic [IDX_W-1:0]  next_idx;

    slot_bitmap #(
        .N_SLOTS (N_SLOTS),
        .IDX_W   (IDX_W)
    ) u_bitmap (
        .clk     (clk),
        .rst     (rst),
        .clear   (bm_clear),
        .set_en  (bm_set_en),
        .set_idx (bus.wr_idx),
        .dup     (bm_dup),
        .accept  (bm_accept),
        .all_set (bm_all_set)
    );

    // The opening sweep_start cycle already counts as collecting, so its write lands.
    always_comb begin
        collecting   = (state_q == COLLECT) || ((state_q == IDLE) && sweep_start);
        bm_clear     = (state_q == IDLE) && sweep_start;
        bm_set_en    = collecting && bus.wr_en;
        rd_fire      = (state_q == DRAIN) && rd_valid_q && bus.rd_ready;
        rd_last      = (rd_idx_q == IDX_W'(N_SLOTS - 1));
        next_idx     = rd_idx_q + IDX_W'(1);

        state_d      = state_q;
        rd_valid_d   = rd_valid_q;
        rd_idx_d     = rd_idx_q;
        rd_data_d    = rd_data_q;
        frame_done_d = 1'b0;
        dup_err_d    = dup_err_q;
        ovr_err_d    = ovr_err_q;
        slot_buf_d   = slot_buf_q;

        if (bm_accept) begin
            slot_buf_d[bus.wr_idx] = bus.wr_data;
        end
        if (bm_dup) begin
            dup_err_d = 1'b1;
        end
        if (sweep_start && (state_q != IDLE)) begin
            ovr_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
            end
            DRAIN: begin
                if (rd_fire) begin
                    if (rd_last) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rd_idx_d  = next_idx;
                        rd_data_d = slot_buf_q[next_idx];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entry 0 is read from the next-state buffer in case the completing write was slot 0.
        if (bm_accept && bm_all_set) begin
            state_d      = DRAIN;
            frame_done_d = 1'b1;
            rd_valid_d   = 1'b1;
            rd_idx_d     = '0;
            rd_data_d    = slot_buf_d[0];
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        slot_buf_q <= slot_buf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            dup_err_q    <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_valid_q   <= rd_valid_d;
            rd_idx_q     <= rd_idx_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            dup_err_q    <= dup_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_idx   = rd_idx_q;
    assign bus.rd_data  = rd_data_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign dup_err      = dup_err_q;
    assign ovr_err      = ovr_err_q;

endmodule

// File: tb/tb_stdp_weight_collector.sv
// Directed bench for stdp_weight_collector: a frame-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_stdp_weight_collector;
    import stdp_pkg::*;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic sweep_start;
    logic frame_done;
    logic busy;
    logic dup_err;
    logic ovr_err;

    stdp_weight_collector_if #(.IDX_W(IW), .DATA_W(DW)) bus ();

    stdp_weight_collector #(
        .N_SLOTS (N),
        .IDX_W   (IW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sweep_start (sweep_start),
        .bus         (bus),
        .frame_done  (frame_done),
        .busy        (busy),
        .dup_err     (dup_err),
        .ovr_err     (ovr_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit compare_en   = 1'b0;
    int fd_count     = 0;
    logic [IW-1:0] beat_idx [$];
    logic [DW-1:0] beat_data [$];

    // Frame-level reference: 0 idle, 1 collecting, 2 draining.
    int      m_phase;
    int      m_old_phase;
    int      m_cnt;
    int      m_ptr;
    bit      m_have [N];
    logic [DW-1:0] m_val [N];
    bit      m_fd;
    bit      m_dup;
    bit      m_ovr;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic start, input logic we, input logic [IW-1:0] idx,
                                  input logic [DW-1:0] data, input logic ready);
        @(posedge clk);
        #1;
        sweep_start  = start;
        bus.wr_en    = we;
        bus.wr_idx   = idx;
        bus.wr_data  = data;
        bus.rd_ready = ready;
    endtask

    task automatic collect_in_order(input logic [DW-1:0] base);
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < N; i++) begin
            apply_stimulus(1'b0, 1'b1, IW'(i), base + DW'(i), 1'b1);
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
        while (busy && c < 60) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
            c++;
        end
        check_output({name, "_drain_ends"}, 32'(busy), 32'd0);
    endtask

    task automatic check_beats(input string name, input logic [DW-1:0] base);
        check_output({name, "_beat_count"}, 32'(beat_idx.size()), 32'd16);
        for (int i = 0; i < beat_idx.size() && i < N; i++) begin
            check_output({name, "_beat_idx"}, 32'(beat_idx[i]), 32'(i));
            check_output({name, "_beat_data"}, 32'(beat_data[i]), 32'(base + DW'(i)));
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_fd    = 1'b0;
            m_dup   = 1'b0;
            m_ovr   = 1'b0;
            for (int i = 0; i < N; i++) m_have[i] = 1'b0;
        end else begin
            m_old_phase = m_phase;
            m_fd = 1'b0;
            if (sweep_start && m_old_phase != 0) m_ovr = 1'b1;
            if (m_old_phase == 0 && sweep_start) begin
                for (int i = 0; i < N; i++) m_have[i] = 1'b0;
                m_phase = 1;
            end
            if (m_phase == 1 && bus.wr_en) begin
                if (int'(bus.wr_idx) >= N || m_have[bus.wr_idx]) begin
                    m_dup = 1'b1;
                end else begin
                    m_have[bus.wr_idx] = 1'b1;
                    m_val[bus.wr_idx]  = bus.wr_data;
                    m_cnt = 0;
                    for (int i = 0; i < N; i++) m_cnt += int'(m_have[i]);
                    if (m_cnt == N) begin
                        m_phase = 2;
                        m_fd    = 1'b1;
                        m_ptr   = 0;
                    end
                end
            end
            if (m_old_phase == 2 && bus.rd_ready) begin
                if (m_ptr == N - 1) m_phase = 0;
                else m_ptr++;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check_output("busy", 32'(busy), 32'(m_phase != 0));
            check_output("frame_done", 32'(frame_done), 32'(m_fd));
            check_output("rd_valid", 32'(bus.rd_valid), 32'(m_phase == 2));
            check_output("dup_err", 32'(dup_err), 32'(m_dup));
            check_output("ovr_err", 32'(ovr_err), 32'(m_ovr));
            if (m_phase == 2) begin
                check_output("rd_idx", 32'(bus.rd_idx), 32'(m_ptr));
                check_output("rd_data", 32'(bus.rd_data), 32'(m_val[m_ptr]));
            end
            if (frame_done) fd_count++;
            if (bus.rd_valid && bus.rd_ready) begin
                beat_idx.push_back(bus.rd_idx);
                beat_data.push_back(bus.rd_data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall;
        bit ovr_sent;
        rst          = 1'b1;
        sweep_start  = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_idx   = '0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_en = 1'b1;
        @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_output("rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        check_output("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_output("rst_errs", {30'd0, dup_err, ovr_err}, 32'd0);

        // Full sweep in slot order.
        beat_idx.delete(); beat_data.delete();
        collect_in_order(8'h10);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
        check_output("t1_frame_done", 32'(frame_done), 32'd1);
        check_output("t1_first_idx", 32'(bus.rd_idx), 32'd0);
        check_output("t1_first_data", 32'(bus.rd_data), 32'h10);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
        check_output("t1_frame_done_pulse", 32'(frame_done), 32'd0);
        wait_idle("t1");
        check_beats("t1", 8'h10);
        check_output("t1_errs", {30'd0, dup_err, ovr_err}, 32'd0);

        // Out-of-order arrival; first write shares the sweep_start cycle.
        beat_idx.delete(); beat_data.delete();
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(k == 0, 1'b1, IW'(15 - k), 8'hA0 + DW'(15 - k), 1'b1);
            apply_stimulus(1'b0, 1'b1, IW'(k), 8'hA0 + DW'(k), 1'b1);
        end
        wait_idle("t2");
        check_beats("t2", 8'hA0);

        // Backpressure while slot 5 is presented.
        beat_idx.delete(); beat_data.delete();
        collect_in_order(8'h50);
        stall = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
            if (bus.rd_valid && bus.rd_idx == IW'(5) && stall < 3) begin
                bus.rd_ready = 1'b0;
                stall++;
                check_output("t3_stall_idx", 32'(bus.rd_idx), 32'd5);
                check_output("t3_stall_data", 32'(bus.rd_data), 32'h55);
            end else if (stall == 3) begin
                stall++;
                apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
                check_output("t3_after_stall_idx", 32'(bus.rd_idx), 32'd6);
            end
        end
        check_output("t3_stall_cycles", 32'(stall), 32'd4);
        wait_idle("t3");
        check_beats("t3", 8'h50);

        // Duplicate write to slot 3 keeps the first value.
        beat_idx.delete(); beat_data.delete();
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < N - 1; i++) begin
            apply_stimulus(1'b0, 1'b1, IW'(i), 8'h30 + DW'(i), 1'b1);
            if (i == 3) apply_stimulus(1'b0, 1'b1, IW'(3), 8'h99, 1'b1);
        end
        apply_stimulus(1'b0, 1'b1, IW'(15), 8'h3F, 1'b1);
        check_output("t4_not_done_yet", {30'd0, frame_done, bus.rd_valid}, 32'd0);
        check_output("t4_dup_err", 32'(dup_err), 32'd1);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
        check_output("t4_frame_done", 32'(frame_done), 32'd1);
        wait_idle("t4");
        check_beats("t4", 8'h30);
        if (beat_data.size() > 3) check_output("t4_slot3", 32'(beat_data[3]), 32'h33);
        check_output("t4_dup_sticky", 32'(dup_err), 32'd1);

        // sweep_start while entry 7 is presented.
        beat_idx.delete(); beat_data.delete();
        collect_in_order(8'h70);
        ovr_sent = 1'b0;
        for (int c = 0; c < 60 && busy; c++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1);
            if (bus.rd_valid && bus.rd_idx == IW'(7) && !ovr_sent) begin
                sweep_start = 1'b1;
                ovr_sent = 1'b1;
            end
        end
        check_output("t5_ovr_sent", 32'(ovr_sent), 32'd1);
        check_output("t5_returns_idle", 32'(busy), 32'd0);
        check_output("t5_ovr_err", 32'(ovr_err), 32'd1);
        check_beats("t5", 8'h70);

        // Reset in the middle of a frame.
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, IW'(i), 8'hE0 + DW'(i), 1'b1);
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("t6_busy_after_rst", 32'(busy), 32'd0);
        check_output("t6_rd_valid_after_rst", 32'(bus.rd_valid), 32'd0);
        check_output("t6_errs_after_rst", {30'd0, dup_err, ovr_err}, 32'd0);
        rst = 1'b0;
        beat_idx.delete(); beat_data.delete();
        fd_count = 0;
        collect_in_order(8'hC0);
        wait_idle("t6");
        check_beats("t6", 8'hC0);
        check_output("t6_frame_done_count", 32'(fd_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
